// File: rtl/aes_round_sequencer_if.sv
// Host handshakes and datapath/key-store controls of the AES-128 round sequencer.
// AES_SEQ_DECRYPT_EN adds the decrypt request bit.
interface aes_round_sequencer_if;
   logic       key_valid;
   logic       key_ready;
   logic       WE_key_generation;
   logic       generation_done;
   logic       data_valid;
   logic       data_ready;
   logic [3:0] read_addr;
   logic       key_sel0;
   logic       round_en;
   logic       first_round;
   logic       last_round;
   logic       out_valid;
   logic       out_ready;
   logic       busy;
   logic       key_error;
`ifdef AES_SEQ_DECRYPT_EN
   logic       decrypt;

   modport master (
      output key_valid, generation_done, data_valid, out_ready, decrypt,
      input  key_ready, WE_key_generation, data_ready, read_addr, key_sel0,
             round_en, first_round, last_round, out_valid, busy, key_error
   );
   modport slave (
      input  key_valid, generation_done, data_valid, out_ready, decrypt,
      output key_ready, WE_key_generation, data_ready, read_addr, key_sel0,
             round_en, first_round, last_round, out_valid, busy, key_error
   );
`else
   modport master (
      output key_valid, generation_done, data_valid, out_ready,
      input  key_ready, WE_key_generation, data_ready, read_addr, key_sel0,
             round_en, first_round, last_round, out_valid, busy, key_error
   );
   modport slave (
      input  key_valid, generation_done, data_valid, out_ready,
      output key_ready, WE_key_generation, data_ready, read_addr, key_sel0,
             round_en, first_round, last_round, out_valid, busy, key_error
   );
`endif
endinterface

// File: rtl/aes_round_sequencer.sv
// AES-128 key-generation and round sequencer; block result 12 cycles after accept (13 for decrypt).
// No accept while busy; OUT holds until out_ready. AES_SEQ_DECRYPT_EN enables the decrypt sequence.
module aes_round_sequencer #(
   parameter int KEYGEN_MIN_CYCLES = 12,
   parameter int KEYGEN_TIMEOUT    = 64,
   parameter int NUM_ROUNDS        = 10
) (
   input logic             clk,
   input logic             n_rst,
   aes_round_sequencer_if.slave sif
);
   localparam logic [2:0] S_NOKEY    = 3'd0;
   localparam logic [2:0] S_KEYGEN   = 3'd1;
   localparam logic [2:0] S_READY    = 3'd2;
   localparam logic [2:0] S_PREFETCH = 3'd3;
   localparam logic [2:0] S_ROUND    = 3'd4;
   localparam logic [2:0] S_OUT      = 3'd5;

   localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);
   localparam logic [6:0] MIN_WAIT = 7'(KEYGEN_MIN_CYCLES);
   localparam logic [6:0] MAX_WAIT = 7'(KEYGEN_TIMEOUT);

   logic [2:0] state_q, state_d;
   logic [6:0] wait_q, wait_d;
   logic [3:0] rnd_q, rnd_d;
   logic       key_error_q, key_error_d;
   logic       dec_q, dec_d;
   logic       dec_in;
   logic       key_acc, data_acc;

`ifdef AES_SEQ_DECRYPT_EN
   assign dec_in = sif.decrypt;
`else
   assign dec_in = 1'b0;
`endif

   assign sif.key_ready         = (state_q == S_NOKEY) || (state_q == S_READY);
   assign key_acc               = sif.key_valid && sif.key_ready;
   // A key arriving with a block wins the cycle.
   assign sif.data_ready        = (state_q == S_READY) && !sif.key_valid;
   assign data_acc              = sif.data_ready && sif.data_valid;
   assign sif.WE_key_generation = key_acc;
   assign sif.busy              = !sif.key_ready;
   assign sif.out_valid         = (state_q == S_OUT);
   assign sif.round_en          = (state_q == S_ROUND);
   assign sif.first_round       = (state_q == S_ROUND) && (rnd_q == 4'd0);
   assign sif.last_round        = (state_q == S_ROUND) && (rnd_q == LAST_RND);
   assign sif.key_sel0          = (state_q == S_ROUND) &&
                                  (dec_q ? (rnd_q == LAST_RND) : (rnd_q == 4'd0));
   assign sif.key_error         = key_error_q;

   // Address the key needed by the next round; the store answers one cycle later.
   always_comb begin
      sif.read_addr = 4'd0;
      if (state_q == S_PREFETCH) begin
         sif.read_addr = LAST_RND;
      end else if (state_q == S_ROUND) begin
         if (dec_q)
            sif.read_addr = (rnd_q <= LAST_RND - 4'd2) ? (LAST_RND - 4'd1 - rnd_q) : 4'd0;
         else
            sif.read_addr = (rnd_q < LAST_RND) ? (rnd_q + 4'd1) : LAST_RND;
      end
   end

   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      rnd_d       = rnd_q;
      key_error_d = key_error_q;
      dec_d       = dec_q;
      case (state_q)
         S_NOKEY, S_READY: begin
            if (key_acc) begin
               state_d     = S_KEYGEN;
               wait_d      = 7'd0;
               key_error_d = 1'b0;
            end else if (data_acc) begin
               dec_d   = dec_in;
               rnd_d   = 4'd0;
               state_d = dec_in ? S_PREFETCH : S_ROUND;
            end
         end
         S_KEYGEN: begin
            // A done seen too early may be left over from the previous key.
            if (sif.generation_done && (wait_q >= MIN_WAIT)) begin
               state_d = S_READY;
            end else if (wait_q == MAX_WAIT) begin
               key_error_d = 1'b1;
               state_d     = S_NOKEY;
            end else begin
               wait_d = wait_q + 7'd1;
            end
         end
         S_PREFETCH: begin
            rnd_d   = 4'd0;
            state_d = S_ROUND;
         end
         S_ROUND: begin
            if (rnd_q == LAST_RND)
               state_d = S_OUT;
            else
               rnd_d = rnd_q + 4'd1;
         end
         S_OUT: begin
            if (sif.out_ready)
               state_d = S_READY;
         end
         default: state_d = S_NOKEY;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= S_NOKEY;
         wait_q      <= 7'd0;
         rnd_q       <= 4'd0;
         key_error_q <= 1'b0;
         dec_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         rnd_q       <= rnd_d;
         key_error_q <= key_error_d;
         dec_q       <= dec_d;
      end
   end
endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed-plus-random bench for aes_round_sequencer against a cycle-offset reference model.
module tb_aes_round_sequencer;
   localparam int MINC = 12;
   localparam int TMO  = 64;
   localparam int NR   = 10;

   logic clk = 1'b0;
   logic n_rst = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   n;
   int   d;

   aes_round_sequencer_if sif();
   aes_round_sequencer dut (.clk(clk), .n_rst(n_rst), .sif(sif));

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chki(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept a key; done is driven high from KEYGEN cycle done_at on (never if negative).
   // Returns the number of cycles key_ready stayed low.
   task automatic do_key(input int done_at, output int len);
      sif.key_valid = 1'b1;
      #1;
      chk1("we_on_accept", sif.WE_key_generation, 1'b1);
      tick();
      sif.key_valid = 1'b0;
      len = 0;
      while (len < 200) begin
         sif.generation_done = (done_at >= 0) && (len >= done_at);
         #1;
         if (sif.key_ready) break;
         chk1("we_single_pulse", sif.WE_key_generation, 1'b0);
         chk1("busy_keygen", sif.busy, 1'b1);
         chk4("addr_keygen", sif.read_addr, 4'd0);
         len++;
         tick();
      end
   endtask

   task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Cycles following a block handshake: expected controls derived from which key each
   // round consumes and which key the following round will need.
   task automatic block_body(input bit dec, input int stall);
      int pre;
      int k;
      int used;
      int nxt;
      pre = dec ? 1 : 0;
      for (int o = 1; o <= pre + NR + 1; o++) begin
         tick();
         sif.data_valid = 1'b0;
         sif.key_valid  = 1'($urandom_range(0, 1));
         #1;
         chk1("key_ready_low", sif.key_ready, 1'b0);
         chk1("no_we_midblock", sif.WE_key_generation, 1'b0);
         chk1("busy_block", sif.busy, 1'b1);
         chk1("ov_low_block", sif.out_valid, 1'b0);
         if (o <= pre) begin
            chk4("addr_prefetch", sif.read_addr, 4'(NR));
            chk1("ren_prefetch", sif.round_en, 1'b0);
         end else begin
            k    = o - pre - 1;
            used = dec ? NR - k : k;
            if (dec) nxt = (NR - 1 - k > 0) ? NR - 1 - k : 0;
            else     nxt = (k + 1 < NR) ? k + 1 : NR;
            chk4("addr_round", sif.read_addr, 4'(nxt));
            chk1("ren_round", sif.round_en, 1'b1);
            chk1("first_round", sif.first_round, k == 0);
            chk1("last_round", sif.last_round, k == NR);
            chk1("key_sel0", sif.key_sel0, used == 0);
         end
      end
      tick();
      sif.key_valid  = 1'b0;
      sif.data_valid = 1'b1;
      sif.out_ready  = 1'b0;
      #1;
      chk1("ov_rise", sif.out_valid, 1'b1);
      chk1("ren_out", sif.round_en, 1'b0);
      for (int s = 0; s < stall; s++) begin
         chk1("ov_stall", sif.out_valid, 1'b1);
         chk1("dr_stall", sif.data_ready, 1'b0);
         tick();
         #1;
      end
      sif.out_ready = 1'b1;
      #1;
      chk1("ov_hs", sif.out_valid, 1'b1);
      chk1("dr_hs", sif.data_ready, 1'b0);
      tick();
      sif.out_ready  = 1'b0;
      sif.data_valid = 1'b0;
      #1;
      chk1("ov_after", sif.out_valid, 1'b0);
      chk1("dr_after", sif.data_ready, 1'b1);
      chk1("busy_after", sif.busy, 1'b0);
   endtask

   task automatic run_block(input bit dec, input int stall);
      sif.data_valid = 1'b1;
`ifdef AES_SEQ_DECRYPT_EN
      sif.decrypt = dec;
`endif
      #1;
      chk1("dr_accept", sif.data_ready, 1'b1);
      block_body(dec, stall);
   endtask

   initial begin
      sif.key_valid       = 1'b0;
      sif.generation_done = 1'b0;
      sif.data_valid      = 1'b0;
      sif.out_ready       = 1'b0;
`ifdef AES_SEQ_DECRYPT_EN
      sif.decrypt         = 1'b0;
`endif
      #12;
      chk1("rst_key_ready", sif.key_ready, 1'b1);
      chk1("rst_we", sif.WE_key_generation, 1'b0);
      chk1("rst_data_ready", sif.data_ready, 1'b0);
      chk1("rst_busy", sif.busy, 1'b0);
      chk1("rst_key_error", sif.key_error, 1'b0);
      chk4("rst_addr", sif.read_addr, 4'd0);
      chk1("rst_out_valid", sif.out_valid, 1'b0);
      chk1("rst_round_en", sif.round_en, 1'b0);
      n_rst = 1'b1;

      // Stale done held high: READY only once the mask window has elapsed.
      tick();
      do_key(0, n);
      chki("kg_len_stale", n, MINC + 1);
      chk1("ready_dr", sif.data_ready, 1'b1);

      tick();
      run_block(1'b0, 5);

      // Generation never completes.
      tick();
      do_key(-1, n);
      chki("kg_len_timeout", n, TMO + 1);
      chk1("timeout_err", sif.key_error, 1'b1);
      chk1("timeout_nokey_dr", sif.data_ready, 1'b0);
      chk1("timeout_busy", sif.busy, 1'b0);

      tick();
      d = $urandom_range(0, 40);
      do_key(d, n);
      chki("kg_len_rand", n, ((d > MINC) ? d : MINC) + 1);
      chk1("err_cleared", sif.key_error, 1'b0);

      for (int i = 0; i < 4; i++) begin
         tick();
         run_block(1'b0, $urandom_range(0, 6));
         if ($urandom_range(0, 1) == 1) begin
            tick();
            d = $urandom_range(0, 30);
            do_key(d, n);
            chki("kg_len_loop", n, ((d > MINC) ? d : MINC) + 1);
         end
      end

      // Key and block together in READY: key wins, block waits for the new generation.
      tick();
      sif.key_valid       = 1'b1;
      sif.data_valid      = 1'b1;
      sif.generation_done = 1'b1;
      #1;
      chk1("coll_we", sif.WE_key_generation, 1'b1);
      chk1("coll_dr", sif.data_ready, 1'b0);
      tick();
      sif.key_valid = 1'b0;
      n = 0;
      while (n < 200) begin
         #1;
         if (sif.data_ready) break;
         n++;
         tick();
      end
      chki("coll_wait", n, MINC + 1);
      block_body(1'b0, 0);

      // Asynchronous reset in the middle of a block.
      tick();
      sif.data_valid = 1'b1;
      #1;
      tick();
      sif.data_valid = 1'b0;
      tick();
      tick();
      #1;
      n_rst = 1'b0;
      #1;
      chk1("mid_rst_key_ready", sif.key_ready, 1'b1);
      chk1("mid_rst_busy", sif.busy, 1'b0);
      chk1("mid_rst_ren", sif.round_en, 1'b0);
      chk4("mid_rst_addr", sif.read_addr, 4'd0);
      chk1("mid_rst_dr", sif.data_ready, 1'b0);
      n_rst = 1'b1;
      tick();
      do_key(3, n);
      chki("kg_len_post_rst", n, MINC + 1);

`ifdef AES_SEQ_DECRYPT_EN
      tick();
      run_block(1'b1, 2);
      for (int i = 0; i < 3; i++) begin
         tick();
         run_block(1'($urandom_range(0, 1)), $urandom_range(0, 4));
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
- Controller that sequences the AES-128 key generator and the round datapath.
- Accepts a cipher key and launches round-key generation, then waits for it to finish.
- Accepts data blocks and steps the datapath through rounds 0..10, addressing round keys one cycle ahead to absorb the key store's registered read latency.
- Sits between the host-side valid/ready interfaces and the key_generator / round-datapath pair.

Parameters:
- KEYGEN_MIN_CYCLES, 12: cycles after the WE_key_generation pulse during which generation_done is ignored (masks a stale done from a previous key).
- KEYGEN_TIMEOUT, 64: cycles after the pulse by which generation_done must be seen, else key_error.
- NUM_ROUNDS, 10: final round index (AES-128).

Ports:
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- key_valid  in  1  host presents a new cipher key
- key_ready  out  1  sequencer can accept a key
- WE_key_generation  out  1  one-cycle pulse that loads the key and starts generation
- generation_done  in  1  key generator finished (level)
- data_valid  in  1  host presents a block
- data_ready  out  1  sequencer accepts the block; the datapath captures it on the handshake
- read_addr  out  4  round-key index to the key store; key is valid on round_key_x the next cycle
- key_sel0  out  1  datapath uses round_key_0 instead of round_key_x this cycle
- round_en  out  1  datapath executes one round this cycle
- first_round  out  1  AddRoundKey-only round
- last_round  out  1  round without MixColumns
- out_valid  out  1  result held at datapath output
- out_ready  in  1  host consumes the result
- busy  out  1  state is not NOKEY or READY
- key_error  out  1  sticky generation timeout; cleared by the next key accept

Behaviour:
- Reset values: state NOKEY, key_ready=1, all other outputs 0, counters 0.

State machine:
- NOKEY: key_ready=1, data_ready=0.
  - On key_valid&&key_ready: WE_key_generation=1 for that cycle only; clear key_error; go to KEYGEN.
- KEYGEN: key_ready=0, data_ready=0; wait counter increments every cycle.
  - generation_done is ignored while wait < KEYGEN_MIN_CYCLES.
  - generation_done=1 with wait >= KEYGEN_MIN_CYCLES: go to READY.
  - wait == KEYGEN_TIMEOUT without done: set key_error=1; go to NOKEY.
- READY: key_ready=1, data_ready=1.
  - If key_valid and data_valid are both high, the key wins: data_ready=0 that cycle and the key path is taken as in NOKEY.
  - Otherwise, data handshake: go to ROUND with r=0.
- ROUND (encrypt): round_en=1 every cycle; r counts 0..NUM_ROUNDS.
  - r=0: key_sel0=1, first_round=1, read_addr=1.
  - r=1..9: key_sel0=0, read_addr=r+1.
  - r=10: key_sel0=0, read_addr holds at 10, last_round=1; next state OUT.
- OUT: out_valid=1 held until out_ready=1; out_ready is don't-care outside OUT. On the handshake, go to READY; data_ready is not asserted in the same cycle (no back-to-back accept).

Latency and reads:
- Block accepted at cycle T; rounds occupy T+1..T+11; out_valid rises at T+12.
- read_addr is 0 outside ROUND/PREFETCH; NOKEY and KEYGEN never issue key reads.

Constraints:
- key_ready=0 during ROUND/OUT: a key is never reloaded mid-block.
- Async reset mid-operation: immediate return to NOKEY with all outputs at reset values; any in-flight block is discarded.
- Counter widths: r is 4 bits and never exceeds NUM_ROUNDS; the wait counter is 7 bits and saturates at KEYGEN_TIMEOUT.

Optional Feature:
- Macro AES_SEQ_DECRYPT_EN adds input port decrypt (1 bit), sampled on the data handshake.
- Decrypt blocks:
  - Insert one PREFETCH cycle: read_addr=10, round_en=0.
  - ROUND then runs k=0..10 using key 10-k; read_addr=9-k for k<=8 and 0 afterwards.
  - k=0 (key 10 from round_key_x): first_round=1.
  - k=10: key_sel0=1, last_round=1.
  - Latency is T+13.
- Encrypt blocks are identical with or without the macro.
- Without the macro, the port is absent and only the encrypt sequence exists.

Test Plan:
- Reset, key_valid=1 with generation_done tied high: WE pulse exactly one cycle; READY is entered only at wait=12; key_ready=0 during KEYGEN.
- Key accepted, generation_done held 0: key_error=1 at wait=64 and the state returns to NOKEY. A subsequent key accept clears key_error.
- Encrypt block at cycle T: read_addr sequence 1,2..10,10 across T+1..T+11; first_round at T+1 only; last_round at T+11 only; out_valid at T+12.
- Hold out_ready=0 for 5 cycles in OUT: out_valid stays 1, data_ready stays 0. One cycle after out_ready=1, data_ready returns to 1.
- In READY, key_valid and data_valid rise together: the key is accepted, data_ready=0, and the block is accepted only after the new generation completes.
- With AES_SEQ_DECRYPT_EN and decrypt=1: PREFETCH read_addr=10, then read_addr 9..0, key_sel0=1 on the final round, out_valid at T+13.
